cksum_check: RTL

Receive-side checksum verifier for the reconfigurable parser datapath. It sums a byte range of the received header array as 16-bit big-endian one's-complement words, one word per cycle, with the stored checksum field included. It reports pass/fail and the folded sum. It pairs with the checksum generator on the deparser side, and reuses the same level-held start / ready handshake.

---
 rtl/cksum_pkg.sv | 26 ++
 rtl/cksum_word_sel.sv | 35 +++
 rtl/cksum_check.sv | 110 +++++++++++
 3 files changed

// File: rtl/cksum_pkg.sv
// Shared types and constants for the checksum verifier and generator.
// Pure declarations: no latency, no flow control.
package cksum_pkg;

    localparam int HDR_MAX_LEN = 64;
    localparam int ADDR_W      = 8;
    localparam int LEN_W       = 8;

    localparam logic [15:0] CKSUM_GOOD = 16'hFFFF;

    typedef logic [15:0] word16_t;

    typedef enum logic [2:0] {
        ST_FREE  = 3'd0,
        ST_SUM   = 3'd1,
        ST_FOLD1 = 3'd2,
        ST_FOLD2 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Upper half is kept so a second fold can absorb the carry out of the first.
    function automatic logic [31:0] fold32(input logic [31:0] acc);
        return {16'h0000, acc[31:16]} + {16'h0000, acc[15:0]};
    endfunction

endpackage

// File: rtl/cksum_word_sel.sv
// Picks the big-endian 16-bit word at ptr, zero-padding a byte at or past end_a.
// Combinational, zero latency; no flow control.
module cksum_word_sel
    import cksum_pkg::*;
(
    input  logic [8*HDR_MAX_LEN-1:0] pkt_hdr_i,
    input  logic [ADDR_W:0]          ptr,
    input  logic [ADDR_W:0]          end_a,
    output word16_t                  word
);

    localparam int              IDX_W     = $clog2(HDR_MAX_LEN);
    localparam logic [ADDR_W:0] HDR_LIMIT = (ADDR_W+1)'(HDR_MAX_LEN);

    logic [ADDR_W:0] nxt;
    logic [7:0]      hi_byte;
    logic [7:0]      lo_byte;

    assign nxt = ptr + (ADDR_W+1)'(1);

    always_comb begin
        hi_byte = 8'h00;
        lo_byte = 8'h00;
        if (ptr < HDR_LIMIT) begin
            hi_byte = pkt_hdr_i[{ptr[IDX_W-1:0], 3'b000} +: 8];
        end
        // end_a never exceeds the array size here, so nxt < end_a keeps the index in range.
        if (nxt < end_a) begin
            lo_byte = pkt_hdr_i[{nxt[IDX_W-1:0], 3'b000} +: 8];
        end
    end

    assign word = {hi_byte, lo_byte};

endmodule

// File: rtl/cksum_check.sv
// Receive-side one's-complement checksum verifier, one word per cycle; latency ceil(len/2)+3.
// Level-held start_i/done_o handshake: result held until start_i drops, no other backpressure.
module cksum_check
    import cksum_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [8*HDR_MAX_LEN-1:0] pkt_hdr_i,
    input  logic [ADDR_W-1:0]        field_start_i,
    input  logic [LEN_W-1:0]         field_len_i,
    output logic                     done_o,
    output logic                     ok_o,
    output logic                     err_o,
    output logic [15:0]              sum_o
);

    localparam logic [ADDR_W:0] HDR_LIMIT = (ADDR_W+1)'(HDR_MAX_LEN);

    state_t          state;
    logic [31:0]     acc;
    logic [ADDR_W:0] ptr;
    logic [ADDR_W:0] end_a;

    logic [ADDR_W:0] end_calc;
    logic [ADDR_W:0] ptr_nxt2;
    logic [31:0]     acc_fold;
    word16_t         word;

    assign end_calc = {1'b0, field_start_i} + (ADDR_W+1)'(field_len_i);
    assign ptr_nxt2 = ptr + (ADDR_W+1)'(2);
    assign acc_fold = fold32(acc);

    cksum_word_sel u_word_sel (
        .pkt_hdr_i (pkt_hdr_i),
        .ptr       (ptr),
        .end_a     (end_a),
        .word      (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_FREE;
            acc    <= 32'h0;
            ptr    <= '0;
            end_a  <= '0;
            done_o <= 1'b0;
            ok_o   <= 1'b0;
            err_o  <= 1'b0;
            sum_o  <= 16'h0000;
        end else begin
            case (state)
                ST_FREE: begin
                    if (start_i) begin
                        ptr   <= {1'b0, field_start_i};
                        end_a <= end_calc;
                        acc   <= 32'h0;
                        if (end_calc > HDR_LIMIT) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                            ok_o   <= 1'b0;
                            sum_o  <= 16'h0000;
                        end else if (field_len_i == '0) begin
                            state <= ST_FOLD1;
                        end else begin
                            state <= ST_SUM;
                        end
                    end
                end
                ST_SUM: begin
                    acc <= acc + {16'h0000, word};
                    ptr <= ptr_nxt2;
                    if (ptr_nxt2 >= end_a) begin
                        state <= ST_FOLD1;
                    end
                end
                ST_FOLD1: begin
                    acc   <= acc_fold;
                    state <= ST_FOLD2;
                end
                ST_FOLD2: begin
                    sum_o  <= acc_fold[15:0];
                    ok_o   <= (acc_fold[15:0] == CKSUM_GOOD);
                    err_o  <= 1'b0;
                    done_o <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    // A start_i still held high here must not launch a second pass.
                    if (!start_i) begin
                        done_o <= 1'b0;
                        ok_o   <= 1'b0;
                        err_o  <= 1'b0;
                        sum_o  <= 16'h0000;
                        state  <= ST_FREE;
                    end
                end
                default: begin
                    state  <= ST_FREE;
                    done_o <= 1'b0;
                    ok_o   <= 1'b0;
                    err_o  <= 1'b0;
                    sum_o  <= 16'h0000;
                end
            endcase
        end
    end

endmodule
